pc_stream_accum: RTL

PC_STREAM_ACCUM -- requirements
Module: pc_stream_accum

---
 rtl/pc_pkg.sv | 30 +++
 rtl/pc_sn_15_4.sv | 45 ++++
 rtl/pc_stream_accum.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg -- shared types and constants for the popcount stream accumulator.
//
// Contents:
//   PC_IN_W     width of one input word (bits counted per word)
//   PC_CNT_W    width of the per-word popcount result
//   pc_state_e  frame FSM state: ACCUM (taking words) / HOLD (result pending)
//   pc_sum_w    accumulator width for a given frame length
//   pc_wcnt_w   word-count width for a given frame length

package pc_pkg;

  localparam int PC_IN_W  = 15;
  localparam int PC_CNT_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pc_state_e;

  // Wide enough for an all-ones frame, so the running sum can never wrap.
  function automatic int pc_sum_w(input int frame_len);
    return $clog2(PC_IN_W * frame_len + 1);
  endfunction

  // Must be able to hold FRAME_LEN itself, not just FRAME_LEN-1.
  function automatic int pc_wcnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/pc_sn_15_4.sv
// pc_sn_15_4 -- 15:4 counter built from a bit-sorting network.
//
// Ports:
//   in_bits  input  [14:0]  word to count
//   count    output [3:0]   number of set bits in in_bits (0..15)
//
// The bits are sorted so all ones collect at the low end (a thermometer
// code), which is then converted to binary.

module pc_sn_15_4
  import pc_pkg::*;
(
  input  logic [PC_IN_W-1:0]  in_bits,
  output logic [PC_CNT_W-1:0] count
);

  logic [PC_IN_W-1:0] therm;
  logic               hi;
  logic               lo;

  // Odd-even transposition sort: PC_IN_W passes of OR/AND compare-exchange
  // leave therm[k] = 1 exactly when at least k+1 input bits are set.
  always_comb begin
    therm = in_bits;
    hi    = 1'b0;
    lo    = 1'b0;
    for (int p = 0; p < PC_IN_W; p++) begin
      for (int i = p % 2; i < PC_IN_W - 1; i += 2) begin
        hi          = therm[i] | therm[i+1];
        lo          = therm[i] & therm[i+1];
        therm[i]    = hi;
        therm[i+1]  = lo;
      end
    end
  end

  // Thermometer to binary: each bit is set on the count ranges where that
  // binary digit is one; the LSB is simply the parity of the ones.
  assign count[3] = therm[7];
  assign count[2] = (therm[3] & ~therm[7]) | therm[11];
  assign count[1] = (therm[1] & ~therm[3]) | (therm[5] & ~therm[7]) |
                    (therm[9] & ~therm[11]) | therm[13];
  assign count[0] = ^therm;

endmodule

// File: rtl/pc_stream_accum.sv
// pc_stream_accum -- sums the set bits of a stream of 15-bit words per frame.
//
// Parameters:
//   FRAME_LEN   maximum words per frame (2..64)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input word handshake
//   in_data [14:0]       word to popcount
//   in_last              closes the frame with this word
//   out_valid/out_ready  result handshake
//   out_sum [SUM_W]      total set bits in the frame
//   out_words [WCNT_W]   words in the frame (1..FRAME_LEN)
// Build option:
//   PC_ACCUM_PIPE_EN     adds a register stage between counter and accumulator

module pc_stream_accum
  import pc_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  localparam int SUM_W     = pc_sum_w(FRAME_LEN),
  localparam int WCNT_W    = pc_wcnt_w(FRAME_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_IN_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic [WCNT_W-1:0]  out_words
);

  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(FRAME_LEN - 1);

  pc_state_e             state;
  logic [SUM_W-1:0]      acc;
  logic [WCNT_W-1:0]     wcnt;
  logic [PC_CNT_W-1:0]   word_cnt;
  logic                  take;
  logic                  feed_valid;
  logic [PC_CNT_W-1:0]   feed_cnt;
  logic                  feed_close;

  pc_sn_15_4 u_sn (
    .in_bits (in_data),
    .count   (word_cnt)
  );

  assign take = in_valid & in_ready;

`ifdef PC_ACCUM_PIPE_EN
  logic                p_valid;
  logic                p_close;
  logic [PC_CNT_W-1:0] p_cnt;
  logic [WCNT_W-1:0]   seen;

  // Words already in the frame ahead of the one being accepted: those
  // folded into wcnt plus the one sitting in the stage.
  assign seen     = wcnt + WCNT_W'(p_valid);
  assign in_ready = rst_n & (state == ACCUM) & ~(p_valid & p_close);

  // The close decision is made at accept time so the stage can stall the
  // input as soon as a frame-closing word enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_close <= 1'b0;
      p_cnt   <= '0;
    end else begin
      p_valid <= take;
      if (take) begin
        p_cnt   <= word_cnt;
        p_close <= in_last | (seen == LAST_IDX);
      end
    end
  end

  assign feed_valid = p_valid;
  assign feed_cnt   = p_cnt;
  assign feed_close = p_close;
`else
  assign in_ready   = rst_n & (state == ACCUM);
  assign feed_valid = take;
  assign feed_cnt   = word_cnt;
  assign feed_close = in_last | (wcnt == LAST_IDX);
`endif

  // Frame FSM: accumulate until the closing word, then publish the total
  // and hold it until downstream takes it. The handshake cycle accepts no
  // input because in_ready is low throughout HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (feed_valid) begin
            if (feed_close) begin
              out_sum   <= acc + SUM_W'(feed_cnt);
              out_words <= wcnt + WCNT_W'(1);
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc  <= acc + SUM_W'(feed_cnt);
              wcnt <= wcnt + WCNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            wcnt      <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
